// File: rtl/vid_pkg.sv
// Shared video-path types and constants: pixel colour, sync bundle and the CRC-32 polynomial.
package vid_pkg;

    // CRC-32/MPEG-2 generator polynomial (non-reflected)
    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic hsync;
        logic hblank;
        logic vsync;
        logic vblank;
    } vid_sync_t;

    function automatic vid_sync_t pack_sync(input logic hsync, input logic hblank,
                                            input logic vsync, input logic vblank);
        vid_sync_t s;
        s.hsync  = hsync;
        s.hblank = hblank;
        s.vsync  = vsync;
        s.vblank = vblank;
        return s;
    endfunction

    function automatic rgb_t pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
        rgb_t p;
        p.r = r;
        p.g = g;
        p.b = b;
        return p;
    endfunction

endpackage

// File: rtl/vid_crc32_step.sv
// One-clock CRC-32/MPEG-2 update over a 24-bit word, MSB first; purely combinational.
module vid_crc32_step
    import vid_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [23:0] data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // 24 unrolled shift-and-conditional-xor bit steps
    always_comb begin
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC32_POLY : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/vid_frame_crc.sv
// Pixel-bus monitor: per-frame line width / line count / CRC-32 of active RGB,
// published through a valid/ack result register with sticky overrun flag.
module vid_frame_crc
    import vid_pkg::*;
#(
    parameter int unsigned H_W      = 12,
    parameter int unsigned V_W      = 11,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    input  logic           hsync,
    input  logic           hblank,
    input  logic           vsync,
    input  logic           vblank,
    input  logic [7:0]     R,
    input  logic [7:0]     G,
    input  logic [7:0]     B,
    input  logic           res_ack,
    output logic           res_valid,
    output logic [31:0]    res_crc,
    output logic [H_W-1:0] res_width,
    output logic [V_W-1:0] res_lines,
    output logic           res_line_err,
    output logic           res_overrun,
    output logic           frame_done
);

    localparam logic [H_W-1:0] PixMax  = '1;
    localparam logic [V_W-1:0] LineMax = '1;

    vid_sync_t sync;
    rgb_t      pix;
    logic      unused_sync;

    assign sync        = pack_sync(hsync, hblank, vsync, vblank);
    assign pix         = pack_rgb(R, G, B);
    assign unused_sync = sync.hsync ^ sync.vsync;

    logic [31:0]    crc_q, crc_d, crc_stepped;
    logic [H_W-1:0] line_pix_q, line_pix_d;
    logic [V_W-1:0] lines_q, lines_d;
    logic [H_W-1:0] width_q, width_d;
    logic           line_err_q, line_err_d;
    logic           prev_hblank_q, prev_hblank_d;
    logic           prev_vblank_q, prev_vblank_d;
    logic [31:0]    res_crc_q, res_crc_d;
    logic [H_W-1:0] res_width_q, res_width_d;
    logic [V_W-1:0] res_lines_q, res_lines_d;
    logic           res_line_err_q, res_line_err_d;
    logic           res_valid_q, res_valid_d;
    logic           res_overrun_q, res_overrun_d;
    logic           frame_done_q, frame_done_d;

    logic           active, hb_rise, vb_rise, frame_end, close_line;
    logic [V_W-1:0] lines_c;
    logic [H_W-1:0] width_c;
    logic           err_c;

    vid_crc32_step u_crc_step (
        .crc_in  (crc_q),
        .data    (pix),
        .crc_out (crc_stepped)
    );

    // Event decode plus the accumulator values after closing the current line
    always_comb begin
        active     = pix_en & ~sync.hblank & ~sync.vblank;
        hb_rise    = pix_en & ~prev_hblank_q & sync.hblank & ~sync.vblank;
        vb_rise    = pix_en & ~prev_vblank_q & sync.vblank;
        frame_end  = vb_rise & ((lines_q != '0) | (line_pix_q != '0));
        // A frame end with an open line closes that line first
        close_line = (hb_rise | frame_end) & (line_pix_q != '0);
        lines_c    = lines_q;
        width_c    = width_q;
        err_c      = line_err_q;
        if (close_line) begin
            lines_c = (lines_q == LineMax) ? lines_q : lines_q + V_W'(1);
            if (lines_q == '0) begin
                width_c = line_pix_q;
            end else if (line_pix_q != width_q) begin
                err_c = 1'b1;
            end
        end
    end

    // Next state for accumulators, result registers and handshake
    always_comb begin
        crc_d          = crc_q;
        line_pix_d     = line_pix_q;
        lines_d        = lines_q;
        width_d        = width_q;
        line_err_d     = line_err_q;
        prev_hblank_d  = prev_hblank_q;
        prev_vblank_d  = prev_vblank_q;
        res_crc_d      = res_crc_q;
        res_width_d    = res_width_q;
        res_lines_d    = res_lines_q;
        res_line_err_d = res_line_err_q;
        res_valid_d    = res_valid_q;
        res_overrun_d  = res_overrun_q;
        frame_done_d   = 1'b0;

        if (pix_en) begin
            prev_hblank_d = sync.hblank;
            prev_vblank_d = sync.vblank;
        end
        if (active) begin
            crc_d      = crc_stepped;
            line_pix_d = (line_pix_q == PixMax) ? line_pix_q : line_pix_q + H_W'(1);
        end
        if (close_line) begin
            line_pix_d = '0;
            lines_d    = lines_c;
            width_d    = width_c;
            line_err_d = err_c;
        end
        if (frame_end) begin
            res_crc_d      = crc_q;
            res_width_d    = width_c;
            res_lines_d    = lines_c;
            res_line_err_d = err_c;
            frame_done_d   = 1'b1;
            res_valid_d    = 1'b1;
            if (res_valid_q && !res_ack) begin
                res_overrun_d = 1'b1;
            end
            crc_d      = CRC_INIT;
            line_pix_d = '0;
            lines_d    = '0;
            width_d    = '0;
            line_err_d = 1'b0;
        end else if (res_valid_q && res_ack) begin
            res_valid_d = 1'b0;
        end
    end

    // State registers; blanking history resets high so the first frame needs a real edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q          <= CRC_INIT;
            line_pix_q     <= '0;
            lines_q        <= '0;
            width_q        <= '0;
            line_err_q     <= 1'b0;
            prev_hblank_q  <= 1'b1;
            prev_vblank_q  <= 1'b1;
            res_crc_q      <= '0;
            res_width_q    <= '0;
            res_lines_q    <= '0;
            res_line_err_q <= 1'b0;
            res_valid_q    <= 1'b0;
            res_overrun_q  <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            crc_q          <= crc_d;
            line_pix_q     <= line_pix_d;
            lines_q        <= lines_d;
            width_q        <= width_d;
            line_err_q     <= line_err_d;
            prev_hblank_q  <= prev_hblank_d;
            prev_vblank_q  <= prev_vblank_d;
            res_crc_q      <= res_crc_d;
            res_width_q    <= res_width_d;
            res_lines_q    <= res_lines_d;
            res_line_err_q <= res_line_err_d;
            res_valid_q    <= res_valid_d;
            res_overrun_q  <= res_overrun_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_crc      = res_crc_q;
    assign res_width    = res_width_q;
    assign res_lines    = res_lines_q;
    assign res_line_err = res_line_err_q;
    assign res_overrun  = res_overrun_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_vid_frame_crc.sv
// Bench for vid_frame_crc: directed and random frames against a frame-level reference model.
module tb_vid_frame_crc;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en = 1'b0, hsync = 1'b0, hblank = 1'b1, vsync = 1'b0, vblank = 1'b1;
    logic [7:0]  R = 8'h0, G = 8'h0, B = 8'h0;
    logic        res_ack = 1'b0;
    logic        res_valid, res_line_err, res_overrun, frame_done;
    logic [31:0] res_crc;
    logic [11:0] res_width;
    logic [10:0] res_lines;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_ack = 1'b0;

    vid_frame_crc dut (
        .clk          (clk),
        .reset        (reset),
        .pix_en       (pix_en),
        .hsync        (hsync),
        .hblank       (hblank),
        .vsync        (vsync),
        .vblank       (vblank),
        .R            (R),
        .G            (G),
        .B            (B),
        .res_ack      (res_ack),
        .res_valid    (res_valid),
        .res_crc      (res_crc),
        .res_width    (res_width),
        .res_lines    (res_lines),
        .res_line_err (res_line_err),
        .res_overrun  (res_overrun),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Byte-wise CRC-32/MPEG-2 over a whole frame's colour bytes
    function automatic logic [31:0] crc_of(input byte_q_t q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {q[i], 24'h0};
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: collect line widths and colour bytes, summarise at frame end
    int          cur = 0;
    int          widths[$];
    byte_q_t     bytes;
    bit          ph = 1'b1, pv = 1'b1, m_fe;
    logic [31:0] e_crc = 0;
    int          e_width = 0, e_lines = 0;
    bit          e_err = 0, e_valid = 0, e_ovr = 0, e_done = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cur = 0; widths.delete(); bytes.delete(); ph = 1'b1; pv = 1'b1;
            e_crc = 0; e_width = 0; e_lines = 0; e_err = 0; e_valid = 0; e_ovr = 0; e_done = 0;
        end else begin
            m_fe = 1'b0;
            if (pix_en) begin
                if (!hblank && !vblank) begin
                    bytes.push_back(R); bytes.push_back(G); bytes.push_back(B);
                    if (cur < 4095) cur++;
                end
                if (!ph && hblank && !vblank && cur > 0) begin
                    widths.push_back(cur); cur = 0;
                end
                if (!pv && vblank && (widths.size() > 0 || cur > 0)) begin
                    if (cur > 0) begin widths.push_back(cur); cur = 0; end
                    m_fe = 1'b1;
                end
                ph = hblank; pv = vblank;
            end
            if (m_fe) begin
                e_crc   = crc_of(bytes);
                e_width = widths[0];
                e_lines = (widths.size() > 2047) ? 2047 : widths.size();
                e_err   = 1'b0;
                foreach (widths[i]) if (widths[i] != widths[0]) e_err = 1'b1;
                e_ovr   = e_ovr | (e_valid & !res_ack);
                e_valid = 1'b1;
                widths.delete(); bytes.delete();
            end else if (e_valid && res_ack) begin
                e_valid = 1'b0;
            end
            e_done = m_fe;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("res_valid", 32'(res_valid), 32'(e_valid));
        check("res_crc", res_crc, e_crc);
        check("res_width", 32'(res_width), 32'(e_width));
        check("res_lines", 32'(res_lines), 32'(e_lines));
        check("res_line_err", 32'(res_line_err), 32'(e_err));
        check("res_overrun", 32'(res_overrun), 32'(e_ovr));
        check("frame_done", 32'(frame_done), 32'(e_done));
    end

    task automatic cyc(input bit en, input bit hb, input bit vb, input logic [23:0] px,
                       input bit ack);
        pix_en = en; hblank = hb; vblank = vb; {R, G, B} = px; res_ack = ack;
        hsync = 1'($urandom); vsync = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    // mode 0: no gaps, 1: two pix_en=0 cycles before each sample, 2: random gaps
    task automatic idle_gap(input int mode);
        int n;
        n = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'($urandom), 1'($urandom), 24'($urandom), rand_ack ? 1'($urandom) : 1'b0);
    endtask

    task automatic send_px(input logic [23:0] px, input int mode);
        idle_gap(mode);
        cyc(1'b1, 1'b0, 1'b0, px, 1'b0);
    endtask

    task automatic send_line(input int w, input int mode, input bit cst, input logic [23:0] cp);
        for (int i = 0; i < w; i++) send_px(cst ? cp : 24'($urandom), mode);
        idle_gap(mode);
        cyc(1'b1, 1'b1, 1'b0, 24'($urandom), 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 24'($urandom), 1'b0);
    endtask

    task automatic end_frame(input int mode, input bit ack);
        idle_gap(mode);
        cyc(1'b1, 1'b1, 1'b1, 24'($urandom), ack);
    endtask

    task automatic do_ack();
        cyc(1'b0, 1'b1, 1'b1, 24'h0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 24'h0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(res_valid), 32'h0);
        check("rst_crc", res_crc, 32'h0);
        check("rst_overrun", 32'(res_overrun), 32'h0);
        reset = 1'b0;
    endtask

    // Three pixels "123","456","789"; the vblank edge arrives with the line still open
    task automatic test1(input int mode);
        send_px(24'h313233, mode);
        send_px(24'h343536, mode);
        send_px(24'h373839, mode);
        idle_gap(mode);
        cyc(1'b1, 1'b0, 1'b1, 24'hABCDEF, 1'b0);
        check("t1_crc", res_crc, 32'h0376E6E7);
        check("t1_width", 32'(res_width), 32'd3);
        check("t1_lines", 32'(res_lines), 32'd1);
        check("t1_err", 32'(res_line_err), 32'd0);
        check("t1_done", 32'(frame_done), 32'd1);
        do_ack();
    endtask

    initial begin
        byte_q_t pin;
        pin = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_crc_pin", crc_of(pin), 32'h0376E6E7);

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(res_valid), 32'h0);
        check("reset_done", 32'(frame_done), 32'h0);
        reset = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 24'h0, 1'b0);

        test1(0);

        // Blanking-only frame: vblank rises with no active pixels
        cyc(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 24'h0, 1'b0);
        check("empty_done", 32'(frame_done), 32'd0);
        check("empty_valid", 32'(res_valid), 32'd0);

        // 4 x 640 constant black
        for (int l = 0; l < 4; l++) send_line(640, 0, 1'b1, 24'h000000);
        end_frame(0, 1'b0);
        check("t2_done_hi", 32'(frame_done), 32'd1);
        check("t2_width", 32'(res_width), 32'd640);
        check("t2_lines", 32'(res_lines), 32'd4);
        check("t2_err", 32'(res_line_err), 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 24'h0, 1'b0);
        check("t2_done_lo", 32'(frame_done), 32'd0);
        do_ack();

        // 8,8,7 then 8,8
        send_line(8, 0, 1'b0, 24'h0); send_line(8, 0, 1'b0, 24'h0); send_line(7, 0, 1'b0, 24'h0);
        end_frame(0, 1'b0);
        check("t3_err", 32'(res_line_err), 32'd1);
        check("t3_width", 32'(res_width), 32'd8);
        check("t3_lines", 32'(res_lines), 32'd3);
        do_ack();
        send_line(8, 0, 1'b0, 24'h0); send_line(8, 0, 1'b0, 24'h0);
        end_frame(0, 1'b0);
        check("t3b_err", 32'(res_line_err), 32'd0);
        do_ack();

        // Overrun: two frames without ack
        send_line(5, 0, 1'b0, 24'h0); send_line(5, 0, 1'b0, 24'h0);
        end_frame(0, 1'b0);
        send_line(6, 0, 1'b0, 24'h0); send_line(6, 0, 1'b0, 24'h0); send_line(6, 0, 1'b0, 24'h0);
        end_frame(0, 1'b0);
        check("t4_ovr", 32'(res_overrun), 32'd1);
        check("t4_lines", 32'(res_lines), 32'd3);
        check("t4_width", 32'(res_width), 32'd6);
        do_reset();
        send_line(5, 0, 1'b0, 24'h0); send_line(5, 0, 1'b0, 24'h0);
        end_frame(0, 1'b0);
        send_line(6, 0, 1'b0, 24'h0); send_line(6, 0, 1'b0, 24'h0); send_line(6, 0, 1'b0, 24'h0);
        end_frame(0, 1'b1);
        check("t4b_ovr", 32'(res_overrun), 32'd0);
        check("t4b_valid", 32'(res_valid), 32'd1);
        check("t4b_lines", 32'(res_lines), 32'd3);
        do_ack();

        // pix_en gating: 1-of-3 sampling, then vblank hidden behind pix_en=0
        test1(1);
        send_line(5, 0, 1'b0, 24'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 24'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
        check("t5_nofe_valid", 32'(res_valid), 32'd0);
        send_line(5, 0, 1'b0, 24'h0);
        end_frame(0, 1'b0);
        check("t5_lines", 32'(res_lines), 32'd2);
        do_ack();

        // Reset mid-line discards the partial frame
        cyc(1'b1, 1'b0, 1'b0, 24'h313233, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 24'h343536, 1'b0);
        do_reset();
        test1(0);

        // Random frames, random gaps and random acks
        rand_ack = 1'b1;
        for (int f = 0; f < 25; f++) begin
            int nl, w0;
            nl = $urandom_range(1, 5);
            w0 = $urandom_range(1, 12);
            for (int l = 0; l < nl; l++)
                send_line(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : w0,
                          $urandom_range(0, 2), 1'b0, 24'h0);
            end_frame($urandom_range(0, 2), 1'($urandom));
            for (int i = 0; i < 2; i++) cyc(1'($urandom), 1'b1, 1'b1, 24'h0, 1'($urandom));
        end
        rand_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
